display_scan_controller: RTL and testbench



---
 rtl/display_scan_controller.sv | 112 +++++++++++
 tb/tb_display_scan_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Time-multiplexed digit scanner feeding a shared decoder: double-buffered digit
// registers, one-hot digit enables with a dark guard interval, leading-zero ripple chain.
module display_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int PERIOD_W   = 10,
  localparam int AW        = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_en,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [3:0]            guard,
  input  logic                  rbz_en,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  commit,
  input  logic                  dec_rbo_n,
  output logic [7:0]            dec_code,
  output logic                  dec_rbi_n,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_start,
  output logic                  commit_pending
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [AW-1:0] MSD = AW'(NUM_DIGITS - 1);

  state_t              state, nstate;
  logic [AW-1:0]       idx, nidx;
  logic [PERIOD_W-1:0] cnt, ncnt;
  logic [7:0]          shadow      [NUM_DIGITS];
  logic [7:0]          active      [NUM_DIGITS];
  logic [7:0]          active_next [NUM_DIGITS];
  logic                dwell_end;
  logic                boundary;

  // Outputs are registered from the next-cycle position so they line up with idx/cnt.
  always_comb begin
    dwell_end   = (cnt >= period);
    boundary    = (state == IDLE) || ((idx == '0) && dwell_end);
    active_next = active;
    if (boundary && commit_pending) active_next = shadow;

    nstate = state;
    nidx   = idx;
    ncnt   = cnt;
    case (state)
      IDLE: begin
        if (scan_en) begin
          nstate = SCAN;
          nidx   = MSD;
          ncnt   = '0;
        end
      end
      SCAN: begin
        if (!scan_en) begin
          nstate = IDLE;
          nidx   = MSD;
          ncnt   = '0;
        end else if (dwell_end) begin
          ncnt = '0;
          nidx = (idx == '0) ? MSD : idx - AW'(1);
        end else begin
          ncnt = cnt + PERIOD_W'(1);
        end
      end
      default: begin
        nstate = IDLE;
        nidx   = MSD;
        ncnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= MSD;
      cnt            <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      dec_code       <= '0;
      dec_rbi_n      <= 1'b1;
      dig_sel        <= '0;
      frame_start    <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      state  <= nstate;
      idx    <= nidx;
      cnt    <= ncnt;
      active <= active_next;
      if (wr_en && (int'(wr_addr) < NUM_DIGITS)) shadow[wr_addr] <= wr_data;

      // A commit landing on the boundary itself waits for the following boundary.
      commit_pending <= commit | (commit_pending & ~boundary);

      frame_start <= (nstate == SCAN) && (nidx == MSD) && (ncnt == '0);
      dig_sel     <= ((nstate == SCAN) && (int'(ncnt) >= int'(guard)))
                     ? (NUM_DIGITS'(1) << nidx) : '0;
      dec_code    <= active_next[nidx];

      if ((nstate != SCAN) || (nidx == '0) || !rbz_en) dec_rbi_n <= 1'b1;
      else if (nidx == MSD)                            dec_rbi_n <= 1'b0;
      else if (dwell_end)                              dec_rbi_n <= dec_rbo_n;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: directed scenarios plus random
// traffic checked against a frame-position model of the scan schedule and register banks.
module tb_display_scan_controller;

  localparam int N  = 4;
  localparam int PW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, scan_en, rbz_en, wr_en, commit;
  logic [PW-1:0] period;
  logic [3:0]    guard;
  logic [1:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          dec_rbo_n;
  logic [7:0]    dec_code;
  logic          dec_rbi_n;
  logic [N-1:0]  dig_sel;
  logic          frame_start, commit_pending;

  // Decoder stand-in: blanks (rbo low) when ripple-blank is asserted and the code is zero.
  assign dec_rbo_n = ~(~dec_rbi_n & (dec_code == 8'h00));

  display_scan_controller #(.NUM_DIGITS(N), .PERIOD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .period(period), .guard(guard),
    .rbz_en(rbz_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .dec_rbo_n(dec_rbo_n), .dec_code(dec_code), .dec_rbi_n(dec_rbi_n),
    .dig_sel(dig_sel), .frame_start(frame_start), .commit_pending(commit_pending)
  );

  logic          scan_en3, wr_en3, commit3;
  logic [1:0]    wr_addr3;
  logic [7:0]    wr_data3;
  logic [7:0]    dec_code3;
  logic          dec_rbi_n3, frame_start3, commit_pending3;
  logic [2:0]    dig_sel3;

  display_scan_controller #(.NUM_DIGITS(3), .PERIOD_W(PW)) dut3 (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en3), .period(PW'(0)), .guard(4'd0),
    .rbz_en(1'b0), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .commit(commit3), .dec_rbo_n(1'b1), .dec_code(dec_code3), .dec_rbi_n(dec_rbi_n3),
    .dig_sel(dig_sel3), .frame_start(frame_start3), .commit_pending(commit_pending3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit [7:0]    m_shadow [N];
  bit [7:0]    m_active [N];
  bit          m_pending;
  bit          m_scan;
  int unsigned m_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned cur_digit();
    int unsigned pl = int'(period) + 1;
    return N - 1 - ((m_p / pl) % N);
  endfunction

  function automatic int unsigned cur_cnt();
    int unsigned pl = int'(period) + 1;
    return m_p % pl;
  endfunction

  // Advance one clock, update the reference model with the inputs that edge sampled,
  // then compare every output against it.
  task automatic tick();
    bit          s_rst = rst_n;
    bit          s_en  = scan_en;
    bit          s_wr  = wr_en;
    bit          s_cm  = commit;
    bit [1:0]    s_a   = wr_addr;
    bit [7:0]    s_d   = wr_data;
    int unsigned pl    = int'(period) + 1;
    int unsigned dig, c;
    bit          bnd;
    bit          exp_rbi;
    @(posedge clk);
    #1;
    if (!s_rst) begin
      foreach (m_shadow[i]) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_pending = 1'b0;
      m_scan    = 1'b0;
      m_p       = 0;
    end else begin
      dig = N - 1 - ((m_p / pl) % N);
      c   = m_p % pl;
      bnd = !m_scan || (dig == 0 && c == pl - 1);
      if (bnd && m_pending) m_active = m_shadow;
      if (s_wr && int'(s_a) < N) m_shadow[s_a] = s_d;
      if (s_cm) m_pending = 1'b1;
      else if (bnd) m_pending = 1'b0;
      if (s_en) begin
        if (m_scan) m_p++;
        else begin
          m_scan = 1'b1;
          m_p    = 0;
        end
      end else begin
        m_scan = 1'b0;
        m_p    = 0;
      end
    end

    chk("commit_pending", 32'(commit_pending), 32'(m_pending));
    if (m_scan) begin
      dig = N - 1 - ((m_p / pl) % N);
      c   = m_p % pl;
      chk("dig_sel", 32'(dig_sel), (c >= int'(guard)) ? (32'(1) << dig) : 32'(0));
      chk("frame_start", 32'(frame_start), 32'((m_p % (N * pl)) == 0));
      chk("dec_code", 32'(dec_code), 32'(m_active[dig]));
      exp_rbi = 1'b1;
      if (rbz_en && dig != 0) begin
        exp_rbi = 1'b0;
        for (int k = N - 1; k > int'(dig); k--)
          if (m_active[k] != 0) exp_rbi = 1'b1;
      end
      chk("dec_rbi_n", 32'(dec_rbi_n), 32'(exp_rbi));
    end else begin
      chk("idle_dig_sel", 32'(dig_sel), 32'(0));
      chk("idle_frame_start", 32'(frame_start), 32'(0));
    end
  endtask

  task automatic go_idle();
    scan_en = 1'b0;
    tick();
  endtask

  task automatic write_reg(input int a, input bit [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 2'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    bit          found;
    bit [7:0]    exp3 [3];

    rst_n = 1'b0; scan_en = 1'b0; period = PW'(3); guard = 4'd1; rbz_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    scan_en3 = 1'b0; wr_en3 = 1'b0; commit3 = 1'b0; wr_addr3 = '0; wr_data3 = '0;
    tick();
    tick();
    chk("rst_dec_code", 32'(dec_code), 32'(0));
    chk("rst_dec_rbi_n", 32'(dec_rbi_n), 32'(1));
    chk("rst_dig_sel", 32'(dig_sel), 32'(0));
    chk("rst_frame_start", 32'(frame_start), 32'(0));
    chk("rst_commit_pending", 32'(commit_pending), 32'(0));
    chk("rst_dig_sel3", 32'(dig_sel3), 32'(0));
    rst_n = 1'b1;
    tick();

    // Basic scan, period 3, guard 1
    scan_en = 1'b1;
    tick();
    chk("start_frame_start", 32'(frame_start), 32'(1));
    repeat (40) tick();

    // Double buffering: writes and commit land mid-frame
    for (int i = 0; i < 4; i++) write_reg(i, 8'(i + 1));
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("db_pending_set", 32'(commit_pending), 32'(1));
    repeat (40) tick();
    chk("db_pending_clear", 32'(commit_pending), 32'(0));

    // Leading-zero chain with rbz_en = 1, then 0
    go_idle();
    rbz_en = 1'b1;
    write_reg(3, 8'h00); write_reg(2, 8'h00); write_reg(1, 8'h05); write_reg(0, 8'h00);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    scan_en = 1'b1;
    repeat (20) tick();
    go_idle();
    rbz_en  = 1'b0;
    scan_en = 1'b1;
    repeat (20) tick();

    // Guard longer than dwell: dark digits, frame_start still pulses
    go_idle();
    guard   = 4'd5;
    scan_en = 1'b1;
    repeat (20) tick();

    // Single-cycle dwell, lit with guard 0
    go_idle();
    period  = PW'(0);
    guard   = 4'd0;
    scan_en = 1'b1;
    repeat (12) tick();

    // Disable during digit 1, then restart at MSD
    go_idle();
    period  = PW'(3);
    guard   = 4'd1;
    scan_en = 1'b1;
    tick();
    found = 1'b0;
    for (int t = 0; t < 64 && !found; t++) begin
      if (m_scan && cur_digit() == 1 && cur_cnt() == 2) found = 1'b1;
      else tick();
    end
    chk("wait_digit1", 32'(found), 32'(1));
    scan_en = 1'b0;
    tick();
    chk("disable_dig_sel", 32'(dig_sel), 32'(0));
    scan_en = 1'b1;
    tick();
    chk("restart_frame_start", 32'(frame_start), 32'(1));
    repeat (10) tick();

    // Reset mid-scan clears outputs and both banks
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_dec_code", 32'(dec_code), 32'(0));
    chk("mrst_dec_rbi_n", 32'(dec_rbi_n), 32'(1));
    chk("mrst_dig_sel", 32'(dig_sel), 32'(0));
    chk("mrst_frame_start", 32'(frame_start), 32'(0));
    repeat (20) tick();

    // Commit on the last dwell cycle of digit 0 is serviced one frame later
    for (int i = 0; i < 4; i++) write_reg(i, 8'(8'hA0 + i));
    found = 1'b0;
    for (int t = 0; t < 64 && !found; t++) begin
      if (m_scan && cur_digit() == 0 && cur_cnt() == int'(period)) found = 1'b1;
      else tick();
    end
    chk("wait_boundary", 32'(found), 32'(1));
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("collide_pending", 32'(commit_pending), 32'(1));
    chk("collide_no_copy", 32'(dec_code), 32'(0));
    repeat (40) tick();

    // Random traffic under a few scan settings
    for (int r = 0; r < 4; r++) begin
      go_idle();
      period  = PW'($urandom_range(0, 4));
      guard   = 4'($urandom_range(0, 3));
      rbz_en  = 1'($urandom_range(0, 1));
      scan_en = 1'b1;
      for (int t = 0; t < 250; t++) begin
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        commit  = ($urandom_range(0, 15) == 0);
        scan_en = ($urandom_range(0, 99) != 0);
        tick();
      end
      wr_en  = 1'b0;
      commit = 1'b0;
    end
    go_idle();

    // Three-digit instance: out-of-range write address is ignored
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      wr_en3 = 1'b1; wr_addr3 = 2'(i); wr_data3 = exp3[i];
      tick();
    end
    wr_en3 = 1'b0;
    commit3 = 1'b1;
    tick();
    commit3 = 1'b0;
    tick();
    tick();
    wr_en3 = 1'b1; wr_addr3 = 2'd3; wr_data3 = 8'hEE;
    tick();
    wr_en3 = 1'b0;
    commit3 = 1'b1;
    tick();
    commit3 = 1'b0;
    tick();
    tick();
    chk("d3_pending_clear", 32'(commit_pending3), 32'(0));
    scan_en3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("d3_dec_code", 32'(dec_code3), 32'(exp3[2 - (k % 3)]));
      chk("d3_dig_sel", 32'(dig_sel3), 32'(1) << (2 - (k % 3)));
    end
    scan_en3 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
